quad_decoder: RTL and testbench

- Quadrature front-end that turns raw A/B encoder levels into single-cycle `increment` / `decrement` pulses.
- The pulses drive the team's enable-gated 5-bit up/down counter.
- Pipeline: 2-flop synchronizer, per-channel debounce filter, 4x Gray-code decoder. Illegal double transitions are flagged on `error`.

---
 rtl/quad_decoder.sv | 154 +++++++++++++++
 tb/tb_quad_decoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: 2-flop synchronizer, per-channel debounce and a 4x
// Gray-code decoder producing registered increment/decrement/error pulses.
module quad_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FILT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    output logic       increment,
    output logic       decrement,
    output logic       error,
    output logic       direction,
    output logic [1:0] phase
);

    localparam logic [FILT_W-1:0] CntLast = FILT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FILT_W-1:0] CntOne  = FILT_W'(1);
    localparam logic [1:0]        WarmFull = 2'd2;

    // Channel vectors are packed as {a, b} throughout.
    logic [1:0]        s1_q, s1_d;
    logic [1:0]        s2_q, s2_d;
    logic [1:0]        warm_q, warm_d;
    logic              primed_q, primed_d;
    logic [1:0]        filt_q, filt_d;
    logic [FILT_W-1:0] cnt_a_q, cnt_a_d;
    logic [FILT_W-1:0] cnt_b_q, cnt_b_d;
    logic [1:0]        prev_q, prev_d;
    logic              inc_q, inc_d;
    logic              dec_q, dec_d;
    logic              err_q, err_d;
    logic              dir_q, dir_d;
    logic [1:0]        step;

    function automatic logic [FILT_W-1:0] cnt_next(input logic              raw,
                                                    input logic              filt,
                                                    input logic [FILT_W-1:0] cnt);
        if (raw == filt || cnt == CntLast) begin
            return '0;
        end
        return cnt + CntOne;
    endfunction

    function automatic logic flip(input logic              raw,
                                  input logic              filt,
                                  input logic [FILT_W-1:0] cnt);
        return (raw != filt) && (cnt == CntLast);
    endfunction

    // Position along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ph);
        logic [1:0] idx;
        case (ph)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Modulo-4 distance: 1 forward, 3 reverse, 2 both channels moved.
    assign step = gray_idx(filt_q) - gray_idx(prev_q);

    always_comb begin
        s1_d     = {a_in, b_in};
        s2_d     = s1_q;
        warm_d   = warm_q;
        primed_d = primed_q;
        filt_d   = filt_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        prev_d   = prev_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        err_d    = 1'b0;
        dir_d    = dir_q;

        if (warm_q != WarmFull) begin
            warm_d = warm_q + 2'd1;
        end

        if (!primed_q) begin
            // Adopt whatever phase is present so power-up never emits a pulse.
            if (warm_q == WarmFull) begin
                primed_d = 1'b1;
                filt_d   = s2_q;
                prev_d   = s2_q;
            end
        end else begin
            cnt_a_d = cnt_next(s2_q[1], filt_q[1], cnt_a_q);
            cnt_b_d = cnt_next(s2_q[0], filt_q[0], cnt_b_q);
            if (flip(s2_q[1], filt_q[1], cnt_a_q)) begin
                filt_d[1] = s2_q[1];
            end
            if (flip(s2_q[0], filt_q[0], cnt_b_q)) begin
                filt_d[0] = s2_q[0];
            end

            prev_d = filt_q;
            case (step)
                2'd1: begin
                    inc_d = 1'b1;
                    dir_d = 1'b1;
                end
                2'd3: begin
                    dec_d = 1'b1;
                    dir_d = 1'b0;
                end
                2'd2:    err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            warm_q   <= '0;
            primed_q <= 1'b0;
            filt_q   <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            prev_q   <= '0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            warm_q   <= warm_d;
            primed_q <= primed_d;
            filt_q   <= filt_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            prev_q   <= prev_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
        end
    end

    assign increment = inc_q;
    assign decrement = dec_q;
    assign error     = err_q;
    assign direction = dir_q;
    assign phase     = filt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: expected pulse events are queued with the stimulus and matched
// against events captured from the DUT; a 5-bit up/down counter model is driven by the pulses.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_in = 1'b0;
    logic       b_in = 1'b0;
    logic       increment, decrement, error, direction;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [1:0] code;
        int         cyc;
    } ev_t;

    localparam logic [1:0] EvMulti = 2'd0;
    localparam logic [1:0] EvInc   = 2'd1;
    localparam logic [1:0] EvDec   = 2'd2;
    localparam logic [1:0] EvErr   = 2'd3;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic       cnt_clr = 1'b0;
    logic [4:0] cnt_m;

    quad_decoder #(
        .DEBOUNCE_CYCLES(4),
        .FILT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .a_in(a_in),
        .b_in(b_in),
        .increment(increment),
        .decrement(decrement),
        .error(error),
        .direction(direction),
        .phase(phase)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event capture and the enable-gated (always enabled) 5-bit counter.
    always @(negedge clk) begin
        if (cnt_clr) cnt_m <= '0;
        else if (increment && !decrement) cnt_m <= cnt_m + 5'd1;
        else if (decrement && !increment) cnt_m <= cnt_m - 5'd1;
        if (!reset && (increment || decrement || error)) begin
            if ($countones({increment, decrement, error}) > 1) obs_q.push_back('{EvMulti, cyc});
            else if (increment) obs_q.push_back('{EvInc, cyc});
            else if (decrement) obs_q.push_back('{EvDec, cyc});
            else obs_q.push_back('{EvErr, cyc});
        end
    end

    task automatic set_ab(input logic a, input logic b, input int hold);
        a_in = a;
        b_in = b;
        repeat (hold) @(negedge clk);
    endtask

    // at < 0 means the event time is not checked.
    task automatic expect_ev(input logic [1:0] code, input int at);
        exp_q.push_back('{code, at});
    endtask

    task automatic test_reset();
        ev_t e, o;
        reset = 1'b1;
        set_ab(0, 0, 2);
        checks++; if (increment !== 1'b0) begin errors++; $display("FAIL reset_inc got %b want 0", increment); end
        checks++; if (decrement !== 1'b0) begin errors++; $display("FAIL reset_dec got %b want 0", decrement); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", error); end
        checks++; if (direction !== 1'b0) begin errors++; $display("FAIL reset_dir got %b want 0", direction); end
        checks++; if (phase !== 2'b00) begin errors++; $display("FAIL reset_phase got %b want 00", phase); end
        reset = 1'b0;
        set_ab(0, 0, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL reset_events got %0d want %0d", obs_q.size(), exp_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_forward();
        ev_t e, o;
        expect_ev(EvInc, cyc + 7);
        repeat (3) expect_ev(EvInc, -1);
        set_ab(1, 0, 10); set_ab(1, 1, 10); set_ab(0, 1, 10); set_ab(0, 0, 10);
        checks++; if (direction !== 1'b1) begin errors++; $display("FAIL fwd_dir got %b want 1", direction); end
        checks++; if (phase !== 2'b00) begin errors++; $display("FAIL fwd_phase got %b want 00", phase); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL fwd_events got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.code !== e.code || (e.cyc >= 0 && o.cyc != e.cyc)) begin
                errors++; $display("FAIL fwd_event got code %0d cyc %0d want code %0d cyc %0d",
                                   o.code, o.cyc, e.code, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reverse();
        ev_t e, o;
        repeat (4) expect_ev(EvDec, -1);
        set_ab(0, 1, 10); set_ab(1, 1, 10); set_ab(1, 0, 10); set_ab(0, 0, 10);
        checks++; if (direction !== 1'b0) begin errors++; $display("FAIL rev_dir got %b want 0", direction); end
        checks++; if (phase !== 2'b00) begin errors++; $display("FAIL rev_phase got %b want 00", phase); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rev_events got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.code !== e.code) begin
                errors++; $display("FAIL rev_event got code %0d want code %0d", o.code, e.code);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        ev_t e, o;
        set_ab(1, 0, 3);
        set_ab(0, 0, 12);
        checks++; if (phase !== 2'b00) begin errors++; $display("FAIL glitch_phase got %b want 00", phase); end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL glitch_short got %0d events want 0", obs_q.size());
        end
        obs_q.delete();
        expect_ev(EvInc, cyc + 7);
        expect_ev(EvDec, -1);
        set_ab(1, 0, 4);
        set_ab(0, 0, 12);
        checks++; if (phase !== 2'b00) begin errors++; $display("FAIL glitch_end_phase got %b want 00", phase); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL glitch_events got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.code !== e.code || (e.cyc >= 0 && o.cyc != e.cyc)) begin
                errors++; $display("FAIL glitch_event got code %0d cyc %0d want code %0d cyc %0d",
                                   o.code, o.cyc, e.code, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_illegal();
        ev_t e, o;
        expect_ev(EvErr, cyc + 7);
        set_ab(1, 1, 10);
        checks++; if (phase !== 2'b11) begin errors++; $display("FAIL ill_phase got %b want 11", phase); end
        checks++; if (direction !== 1'b0) begin errors++; $display("FAIL ill_dir got %b want 0", direction); end
        expect_ev(EvInc, -1);
        expect_ev(EvInc, -1);
        set_ab(0, 1, 10);
        set_ab(0, 0, 10);
        checks++; if (direction !== 1'b1) begin errors++; $display("FAIL ill_after_dir got %b want 1", direction); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ill_events got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.code !== e.code || (e.cyc >= 0 && o.cyc != e.cyc)) begin
                errors++; $display("FAIL ill_event got code %0d cyc %0d want code %0d cyc %0d",
                                   o.code, o.cyc, e.code, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_powerup_midop_reset();
        ev_t e, o;
        reset = 1'b1;
        set_ab(1, 1, 2);
        reset = 1'b0;
        set_ab(1, 1, 20);
        checks++; if (phase !== 2'b11) begin errors++; $display("FAIL pwr_phase got %b want 11", phase); end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL pwr_events got %0d want 0", obs_q.size());
        end
        obs_q.delete();
        expect_ev(EvInc, cyc + 7);
        set_ab(0, 1, 10);
        checks++; if (direction !== 1'b1) begin errors++; $display("FAIL mid_pre_dir got %b want 1", direction); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL mid_pre_events got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.code !== e.code || o.cyc != e.cyc) begin
                errors++; $display("FAIL mid_pre_event got code %0d cyc %0d want code %0d cyc %0d",
                                   o.code, o.cyc, e.code, e.cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
        // Reverse change still inside the debounce window when reset hits.
        set_ab(1, 1, 3);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({increment, decrement, error, direction} !== 4'b0000 || phase !== 2'b00) begin
            errors++; $display("FAIL mid_reset_outs got %b%b%b%b ph %b want 0000 ph 00",
                               increment, decrement, error, direction, phase);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        set_ab(1, 1, 20);
        checks++; if (phase !== 2'b11) begin errors++; $display("FAIL mid_phase got %b want 11", phase); end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL mid_events got %0d want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_counter();
        logic [1:0] fwd[4];
        logic [1:0] rev[4];
        ev_t        e, o;
        fwd = '{2'b10, 2'b11, 2'b01, 2'b00};
        rev = '{2'b01, 2'b11, 2'b10, 2'b00};
        reset = 1'b1;
        cnt_clr = 1'b1;
        set_ab(0, 0, 2);
        reset = 1'b0;
        cnt_clr = 1'b0;
        set_ab(0, 0, 20);
        for (int i = 0; i < 40; i++) begin
            expect_ev(EvInc, -1);
            set_ab(fwd[i % 4][1], fwd[i % 4][0], 6);
        end
        repeat (8) @(negedge clk);
        checks++; if (cnt_m !== 5'd8) begin errors++; $display("FAIL cnt_fwd got %0d want 8", cnt_m); end
        for (int i = 0; i < 10; i++) begin
            expect_ev(EvDec, -1);
            set_ab(rev[i % 4][1], rev[i % 4][0], 6);
        end
        repeat (8) @(negedge clk);
        checks++; if (cnt_m !== 5'd30) begin errors++; $display("FAIL cnt_rev got %0d want 30", cnt_m); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL cnt_events got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.code !== e.code) begin
                errors++; $display("FAIL cnt_event got code %0d want code %0d", o.code, e.code);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_powerup_midop_reset();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
